id_ex_reg: RTL and testbench
============================

Name: id_ex_reg

Overview:
- Pipeline register between the ID stage and the EX stage of the 5-stage RV32 core.
- Captures decoded ID fields, including the forwarded rs1/rs2 operands produced by the reg-RAW forwarding mux, and presents them registered to EX.
- Detects load-use hazards: EX-stage load data cannot be forwarded in time. On a hazard it requests a one-cycle ID/IF stall and inserts a bubble into EX.
- Supports flush on redirect and hold on downstream stall. Counts inserted bubbles for performance monitoring.

Parameters:
- ALU_OP_W, 5, width of the ALU operation code.
- CNT_W, 32, width of the bubble counter.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous reset, active-high
- hold_i  in  1  downstream (MEM wait) stall; freeze the register contents
- flush_i  in  1  branch/jump redirect from EX; kill the instruction entering EX
- valid_id_i  in  1  ID holds a real instruction
- pc_id_i  in  32  PC of the ID instruction
- rs1_re_id_i  in  1  rs1 is read
- rs1_addr_id_i  in  5  rs1 index
- rs1_data_id_i  in  32  forwarded rs1 value
- rs2_re_id_i  in  1  rs2 is read
- rs2_addr_id_i  in  5  rs2 index
- rs2_data_id_i  in  32  forwarded rs2 value
- imm_id_i  in  32  sign-extended immediate
- alu_op_id_i  in  ALU_OP_W  ALU operation
- rd_we_id_i  in  1  writes rd
- rd_addr_id_i  in  5  rd index
- mem_re_id_i  in  1  load
- mem_we_id_i  in  1  store
- valid_ex_o  out  1  EX holds a real instruction
- pc_ex_o  out  32  registered PC
- rs1_data_ex_o, rs2_data_ex_o, imm_ex_o  out  32 each  registered operands
- alu_op_ex_o  out  ALU_OP_W  registered ALU op
- rd_we_ex_o  out  1  registered rd write enable, gated by valid
- rd_addr_ex_o  out  5  registered rd index
- mem_re_ex_o, mem_we_ex_o  out  1 each  registered memory controls, gated by valid
- load_use_stall_o  out  1  combinational request to freeze PC and IF/ID
- bubble_cnt_o  out  CNT_W  number of load-use bubbles inserted since reset

Behaviour:
- Reset (async, rst=1): every registered output is 0, bubble_cnt_o is 0, and load_use_stall_o is forced to 0.
- Hazard term (combinational): hz = valid_ex_o & mem_re_ex_o & rd_we_ex_o & (rd_addr_ex_o != 0) & valid_id_i, AND at least one of:
  - rs1_re_id_i & (rs1_addr_id_i == rd_addr_ex_o)
  - rs2_re_id_i & (rs2_addr_id_i == rd_addr_ex_o)
- load_use_stall_o = hz & ~flush_i & ~hold_i.
  - A flush kills the ID instruction, so no stall is requested.
  - During hold the whole pipe is frozen, so no stall is requested.
- Per-edge update priority, highest first:
  1. flush_i: valid_ex_o <= 0, all control outputs <= 0, data fields may load; a flush overrides hold.
  2. hold_i: all registers keep their value.
  3. hz: insert a bubble. valid_ex_o, rd_we_ex_o, mem_re_ex_o and mem_we_ex_o <= 0; bubble_cnt_o increments by 1.
  4. Otherwise: load all ID fields. Control outputs are loaded ANDed with valid_id_i.
- Latency: 1 cycle from ID to EX.
- Back-to-back loads feeding each other produce exactly one bubble per dependent pair. After the bubble, the load is in MEM and forwarding supplies its data.
- A second consecutive hz cannot occur for the same instruction: after the bubble, valid_ex_o is 0.
- Counter: saturates at all-ones and does not wrap.
- A bubble output carries no side effects. With valid_ex_o=0, the outputs rd_we_ex_o, mem_re_ex_o and mem_we_ex_o are always 0.
- rd_addr 0 loads never cause a stall.
- An asserted rst in mid-operation clears state immediately, independent of clk.

Decomposition:
- Shared package cpu_defs_pkg holds:
  - ALU_OP_W and the ALU opcode constants
  - REG_ADDR_W = 5, XLEN = 32
  - a struct id_ex_ctrl_t {valid, rd_we, rd_addr, mem_re, mem_we, alu_op}
- One sub-module, load_use_detect, holds the combinational hz logic. It is reusable by the later ctrl/stall arbiter.

Test Plan:
- Plain flow. Cycle N: valid_id=1, pc=0x100, rs1_data=0x11, rd=5, rd_we=1. Edge N+1: valid_ex=1, pc_ex=0x100, rs1_data_ex=0x11, rd_addr_ex=5.
- Load-use. EX holds lw x5; ID has add x6,x5,x1 with rs1_re=1. Required:
  - load_use_stall_o=1 in that cycle.
  - Next edge: valid_ex=0, mem_re_ex=0, bubble_cnt=1.
  - Following edge: the add enters EX (pc_ex = add's PC).
- No false stall. Each case must give load_use_stall_o=0 and no bubble:
  - EX load with rd=0, ID reads x0.
  - EX non-load (mem_re=0) writing x5, ID reads x5.
  - rs2_re=0 while rs2_addr matches.
- Flush vs hazard. hz conditions true and flush_i=1 together. Required: load_use_stall_o=0, valid_ex=0 next edge, bubble_cnt unchanged.
- Hold. hold_i=1 for 3 cycles with changing ID inputs. Required:
  - Outputs frozen at prior values; load_use_stall_o=0.
  - After release, the current ID fields load.
- Async reset. rst=1 mid-cycle with valid_ex=1 and bubble_cnt=7. Required: all outputs 0 before the next clk edge; the pipe resumes normally after rst falls.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared RV32 core definitions: datapath widths, ALU opcodes and the ID/EX control bundle.
package cpu_defs_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned ALU_OP_W   = 5;

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 5'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 5'd1;
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = 5'd2;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 5'd3;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = 5'd4;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 5'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = 5'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = 5'd7;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 5'd8;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 5'd9;
    localparam logic [ALU_OP_W-1:0] ALU_PASS = 5'd10;

    typedef struct packed {
        logic                  valid;
        logic                  rd_we;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic                  mem_re;
        logic                  mem_we;
        logic [ALU_OP_W-1:0]   alu_op;
    } id_ex_ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard term: a load in EX whose rd is read by the instruction in ID.
module load_use_detect import cpu_defs_pkg::*; (
    input  logic                  ex_valid,
    input  logic                  ex_mem_re,
    input  logic                  ex_rd_we,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  id_valid,
    input  logic                  id_rs1_re,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic                  id_rs2_re,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    output logic                  hazard_c
);

    logic ex_load_c;
    logic src_match_c;

    // x0 is never written, so a load targeting it cannot be a producer
    assign ex_load_c   = ex_valid & ex_mem_re & ex_rd_we & (ex_rd_addr != '0);
    assign src_match_c = (id_rs1_re & (id_rs1_addr == ex_rd_addr))
                       | (id_rs2_re & (id_rs2_addr == ex_rd_addr));
    assign hazard_c    = ex_load_c & id_valid & src_match_c;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush, hold and a saturating bubble counter.
module id_ex_reg #(
    parameter int unsigned ALU_OP_W = 5,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hold_i,
    input  logic                flush_i,
    input  logic                valid_id_i,
    input  logic [31:0]         pc_id_i,
    input  logic                rs1_re_id_i,
    input  logic [4:0]          rs1_addr_id_i,
    input  logic [31:0]         rs1_data_id_i,
    input  logic                rs2_re_id_i,
    input  logic [4:0]          rs2_addr_id_i,
    input  logic [31:0]         rs2_data_id_i,
    input  logic [31:0]         imm_id_i,
    input  logic [ALU_OP_W-1:0] alu_op_id_i,
    input  logic                rd_we_id_i,
    input  logic [4:0]          rd_addr_id_i,
    input  logic                mem_re_id_i,
    input  logic                mem_we_id_i,
    output logic                valid_ex_o,
    output logic [31:0]         pc_ex_o,
    output logic [31:0]         rs1_data_ex_o,
    output logic [31:0]         rs2_data_ex_o,
    output logic [31:0]         imm_ex_o,
    output logic [ALU_OP_W-1:0] alu_op_ex_o,
    output logic                rd_we_ex_o,
    output logic [4:0]          rd_addr_ex_o,
    output logic                mem_re_ex_o,
    output logic                mem_we_ex_o,
    output logic                load_use_stall_o,
    output logic [CNT_W-1:0]    bubble_cnt_o
);

    import cpu_defs_pkg::*;

    localparam int unsigned CTRL_ALU_W = cpu_defs_pkg::ALU_OP_W;

    id_ex_ctrl_t      ctrl_q, ctrl_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  rs1_q, rs1_d;
    logic [XLEN-1:0]  rs2_q, rs2_d;
    logic [XLEN-1:0]  imm_q, imm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hazard_c;

    load_use_detect u_load_use_detect (
        .ex_valid    (ctrl_q.valid),
        .ex_mem_re   (ctrl_q.mem_re),
        .ex_rd_we    (ctrl_q.rd_we),
        .ex_rd_addr  (ctrl_q.rd_addr),
        .id_valid    (valid_id_i),
        .id_rs1_re   (rs1_re_id_i),
        .id_rs1_addr (rs1_addr_id_i),
        .id_rs2_re   (rs2_re_id_i),
        .id_rs2_addr (rs2_addr_id_i),
        .hazard_c    (hazard_c)
    );

    // A flushed or frozen pipe must not also freeze the front end
    assign load_use_stall_o = hazard_c & ~flush_i & ~hold_i & ~rst;

    // Next-state: flush > hold > bubble > normal load
    always_comb begin
        ctrl_d = ctrl_q;
        pc_d   = pc_q;
        rs1_d  = rs1_q;
        rs2_d  = rs2_q;
        imm_d  = imm_q;
        cnt_d  = cnt_q;

        if (flush_i || !hold_i) begin
            pc_d  = pc_id_i;
            rs1_d = rs1_data_id_i;
            rs2_d = rs2_data_id_i;
            imm_d = imm_id_i;
        end

        if (flush_i) begin
            ctrl_d = '0;
        end else if (!hold_i) begin
            ctrl_d.rd_addr = rd_addr_id_i;
            ctrl_d.alu_op  = CTRL_ALU_W'(alu_op_id_i);
            if (hazard_c) begin
                ctrl_d.valid  = 1'b0;
                ctrl_d.rd_we  = 1'b0;
                ctrl_d.mem_re = 1'b0;
                ctrl_d.mem_we = 1'b0;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                ctrl_d.valid  = valid_id_i;
                ctrl_d.rd_we  = rd_we_id_i  & valid_id_i;
                ctrl_d.mem_re = mem_re_id_i & valid_id_i;
                ctrl_d.mem_we = mem_we_id_i & valid_id_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= '0;
            pc_q   <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            imm_q  <= '0;
            cnt_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            pc_q   <= pc_d;
            rs1_q  <= rs1_d;
            rs2_q  <= rs2_d;
            imm_q  <= imm_d;
            cnt_q  <= cnt_d;
        end
    end

    assign valid_ex_o    = ctrl_q.valid;
    assign pc_ex_o       = pc_q;
    assign rs1_data_ex_o = rs1_q;
    assign rs2_data_ex_o = rs2_q;
    assign imm_ex_o      = imm_q;
    assign alu_op_ex_o   = ALU_OP_W'(ctrl_q.alu_op);
    assign rd_we_ex_o    = ctrl_q.rd_we;
    assign rd_addr_ex_o  = ctrl_q.rd_addr;
    assign mem_re_ex_o   = ctrl_q.mem_re;
    assign mem_we_ex_o   = ctrl_q.mem_we;
    assign bubble_cnt_o  = cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed scenarios plus a randomized run against a behavioural model.
module tb_id_ex_reg;

    localparam int unsigned ALU_OP_W = 5;
    localparam int unsigned CNT_W    = 4;
    localparam int          CNT_MAX  = (1 << CNT_W) - 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                hold_i, flush_i, valid_id_i;
    logic [31:0]         pc_id_i, rs1_data_id_i, rs2_data_id_i, imm_id_i;
    logic                rs1_re_id_i, rs2_re_id_i;
    logic [4:0]          rs1_addr_id_i, rs2_addr_id_i, rd_addr_id_i;
    logic [ALU_OP_W-1:0] alu_op_id_i;
    logic                rd_we_id_i, mem_re_id_i, mem_we_id_i;
    logic                valid_ex_o;
    logic [31:0]         pc_ex_o, rs1_data_ex_o, rs2_data_ex_o, imm_ex_o;
    logic [ALU_OP_W-1:0] alu_op_ex_o;
    logic                rd_we_ex_o;
    logic [4:0]          rd_addr_ex_o;
    logic                mem_re_ex_o, mem_we_ex_o;
    logic                load_use_stall_o;
    logic [CNT_W-1:0]    bubble_cnt_o;

    id_ex_reg #(.ALU_OP_W(ALU_OP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .hold_i(hold_i), .flush_i(flush_i),
        .valid_id_i(valid_id_i), .pc_id_i(pc_id_i),
        .rs1_re_id_i(rs1_re_id_i), .rs1_addr_id_i(rs1_addr_id_i), .rs1_data_id_i(rs1_data_id_i),
        .rs2_re_id_i(rs2_re_id_i), .rs2_addr_id_i(rs2_addr_id_i), .rs2_data_id_i(rs2_data_id_i),
        .imm_id_i(imm_id_i), .alu_op_id_i(alu_op_id_i), .rd_we_id_i(rd_we_id_i),
        .rd_addr_id_i(rd_addr_id_i), .mem_re_id_i(mem_re_id_i), .mem_we_id_i(mem_we_id_i),
        .valid_ex_o(valid_ex_o), .pc_ex_o(pc_ex_o), .rs1_data_ex_o(rs1_data_ex_o),
        .rs2_data_ex_o(rs2_data_ex_o), .imm_ex_o(imm_ex_o), .alu_op_ex_o(alu_op_ex_o),
        .rd_we_ex_o(rd_we_ex_o), .rd_addr_ex_o(rd_addr_ex_o), .mem_re_ex_o(mem_re_ex_o),
        .mem_we_ex_o(mem_we_ex_o), .load_use_stall_o(load_use_stall_o), .bubble_cnt_o(bubble_cnt_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural view of what EX should hold
    logic                m_valid, m_rd_we, m_mem_re, m_mem_we;
    logic [31:0]         m_pc, m_rs1, m_rs2, m_imm;
    logic [4:0]          m_rd;
    logic [ALU_OP_W-1:0] m_alu;
    int                  m_cnt;
    bit                  m_data_ok;

    function automatic bit model_hz();
        bit src;
        src = (rs1_re_id_i && rs1_addr_id_i == m_rd) || (rs2_re_id_i && rs2_addr_id_i == m_rd);
        return m_valid && m_mem_re && m_rd_we && (m_rd != 5'd0) && valid_id_i && src;
    endfunction

    function automatic bit model_stall();
        return model_hz() && !flush_i && !hold_i;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rd_we = 0; m_mem_re = 0; m_mem_we = 0;
        m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_rd = 0; m_alu = 0;
        m_cnt = 0; m_data_ok = 1;
    endtask

    // Advance one rising edge and apply the update rules to the model
    task automatic edge_update();
        bit hz;
        hz = model_hz();
        @(posedge clk);
        if (flush_i) begin
            m_valid = 0; m_rd_we = 0; m_mem_re = 0; m_mem_we = 0; m_data_ok = 0;
        end else if (hold_i) begin
            m_data_ok = m_data_ok;
        end else if (hz) begin
            m_valid = 0; m_rd_we = 0; m_mem_re = 0; m_mem_we = 0; m_data_ok = 0;
            if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        end else begin
            m_valid  = valid_id_i;
            m_rd_we  = rd_we_id_i  & valid_id_i;
            m_mem_re = mem_re_id_i & valid_id_i;
            m_mem_we = mem_we_id_i & valid_id_i;
            m_pc = pc_id_i; m_rs1 = rs1_data_id_i; m_rs2 = rs2_data_id_i;
            m_imm = imm_id_i; m_rd = rd_addr_id_i; m_alu = alu_op_id_i;
            m_data_ok = 1;
        end
        #1;
    endtask

    task automatic rand_id();
        valid_id_i    = 1'($urandom_range(1));
        pc_id_i       = $urandom;
        rs1_re_id_i   = 1'($urandom_range(1));
        rs1_addr_id_i = 5'($urandom_range(31));
        rs1_data_id_i = $urandom;
        rs2_re_id_i   = 1'($urandom_range(1));
        rs2_addr_id_i = 5'($urandom_range(31));
        rs2_data_id_i = $urandom;
        imm_id_i      = $urandom;
        alu_op_id_i   = ALU_OP_W'($urandom_range(31));
        rd_we_id_i    = 1'($urandom_range(1));
        rd_addr_id_i  = 5'($urandom_range(31));
        mem_re_id_i   = 1'($urandom_range(1));
        mem_we_id_i   = 1'($urandom_range(1));
    endtask

    // Present one valid instruction in ID; remaining fields random
    task automatic drive_instr(input logic [31:0] pc, input logic [4:0] rd, input logic rd_we,
                               input logic mem_re, input logic rs1_re, input logic [4:0] rs1a,
                               input logic rs2_re, input logic [4:0] rs2a);
        rand_id();
        valid_id_i = 1; pc_id_i = pc; rd_addr_id_i = rd; rd_we_id_i = rd_we;
        mem_re_id_i = mem_re; mem_we_id_i = 0;
        rs1_re_id_i = rs1_re; rs1_addr_id_i = rs1a; rs2_re_id_i = rs2_re; rs2_addr_id_i = rs2a;
    endtask

    task automatic test_reset();
        rst = 1; hold_i = 0; flush_i = 0;
        rand_id();
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({valid_ex_o, pc_ex_o, rs1_data_ex_o, rs2_data_ex_o, imm_ex_o, alu_op_ex_o,
             rd_we_ex_o, rd_addr_ex_o, mem_re_ex_o, mem_we_ex_o} !== '0) begin
            failures++; $display("FAIL reset_regs valid=%b pc=%h rd=%h", valid_ex_o, pc_ex_o, rd_addr_ex_o);
        end
        checks++;
        if (bubble_cnt_o !== '0) begin
            failures++; $display("FAIL reset_cnt got=%0d exp=0", bubble_cnt_o);
        end
        checks++;
        if (load_use_stall_o !== 1'b0) begin
            failures++; $display("FAIL reset_stall got=%b exp=0", load_use_stall_o);
        end
        rst = 0;
    endtask

    task automatic test_plain_flow();
        @(negedge clk);
        drive_instr(32'h100, 5'd5, 1, 0, 0, 5'd0, 0, 5'd0);
        rs1_data_id_i = 32'h11;
        edge_update();
        checks++;
        if ({valid_ex_o, pc_ex_o, rs1_data_ex_o, rd_addr_ex_o, rd_we_ex_o} !== {1'b1, 32'h100, 32'h11, 5'd5, 1'b1}) begin
            failures++;
            $display("FAIL plain_flow valid=%b pc=%h rs1=%h rd=%0d we=%b exp 1/100/11/5/1",
                     valid_ex_o, pc_ex_o, rs1_data_ex_o, rd_addr_ex_o, rd_we_ex_o);
        end
    endtask

    task automatic test_load_use();
        int cnt0;
        @(negedge clk);
        drive_instr(32'h200, 5'd5, 1, 1, 0, 5'd0, 0, 5'd0);
        edge_update();
        cnt0 = m_cnt;
        @(negedge clk);
        drive_instr(32'h204, 5'd6, 1, 0, 1, 5'd5, 1, 5'd1);
        #1;
        checks++;
        if (load_use_stall_o !== 1'b1) begin
            failures++; $display("FAIL load_use_stall got=%b exp=1", load_use_stall_o);
        end
        edge_update();
        checks++;
        if ({valid_ex_o, mem_re_ex_o, rd_we_ex_o, mem_we_ex_o} !== 4'b0000 || bubble_cnt_o !== CNT_W'(cnt0 + 1)) begin
            failures++;
            $display("FAIL load_use_bubble valid=%b mem_re=%b cnt=%0d exp 0/0/%0d", valid_ex_o, mem_re_ex_o, bubble_cnt_o, cnt0 + 1);
        end
        #1;
        checks++;
        if (load_use_stall_o !== 1'b0) begin
            failures++; $display("FAIL load_use_second_stall got=%b exp=0", load_use_stall_o);
        end
        edge_update();
        checks++;
        if (valid_ex_o !== 1'b1 || pc_ex_o !== 32'h204 || bubble_cnt_o !== CNT_W'(cnt0 + 1)) begin
            failures++; $display("FAIL load_use_resume valid=%b pc=%h cnt=%0d exp 1/204/%0d", valid_ex_o, pc_ex_o, bubble_cnt_o, cnt0 + 1);
        end
    endtask

    task automatic test_no_false_stall();
        int cnt0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            case (c)
                0:       drive_instr(32'h500, 5'd0, 1, 1, 0, 5'd0, 0, 5'd0);
                1:       drive_instr(32'h510, 5'd5, 1, 0, 0, 5'd0, 0, 5'd0);
                default: drive_instr(32'h520, 5'd5, 1, 1, 0, 5'd0, 0, 5'd0);
            endcase
            edge_update();
            cnt0 = m_cnt;
            @(negedge clk);
            case (c)
                0:       drive_instr(32'h504, 5'd7, 1, 0, 1, 5'd0, 1, 5'd0);
                1:       drive_instr(32'h514, 5'd7, 1, 0, 1, 5'd5, 1, 5'd5);
                default: drive_instr(32'h524, 5'd7, 1, 0, 1, 5'd7, 0, 5'd5);
            endcase
            #1;
            checks++;
            if (load_use_stall_o !== 1'b0) begin
                failures++; $display("FAIL no_false_stall case=%0d got=%b exp=0", c, load_use_stall_o);
            end
            edge_update();
            checks++;
            if (valid_ex_o !== 1'b1 || bubble_cnt_o !== CNT_W'(cnt0)) begin
                failures++; $display("FAIL no_false_bubble case=%0d valid=%b cnt=%0d exp 1/%0d", c, valid_ex_o, bubble_cnt_o, cnt0);
            end
        end
    endtask

    task automatic test_flush_vs_hazard();
        int cnt0;
        @(negedge clk);
        drive_instr(32'h600, 5'd5, 1, 1, 0, 5'd0, 0, 5'd0);
        edge_update();
        cnt0 = m_cnt;
        @(negedge clk);
        drive_instr(32'h604, 5'd6, 1, 0, 1, 5'd5, 0, 5'd0);
        flush_i = 1;
        #1;
        checks++;
        if (load_use_stall_o !== 1'b0) begin
            failures++; $display("FAIL flush_stall got=%b exp=0", load_use_stall_o);
        end
        edge_update();
        checks++;
        if ({valid_ex_o, rd_we_ex_o, mem_re_ex_o, mem_we_ex_o} !== 4'b0000 || bubble_cnt_o !== CNT_W'(cnt0)) begin
            failures++; $display("FAIL flush_kill valid=%b rd_we=%b cnt=%0d exp 0/0/%0d", valid_ex_o, rd_we_ex_o, bubble_cnt_o, cnt0);
        end
        flush_i = 0;
    endtask

    task automatic test_hold();
        @(negedge clk);
        drive_instr(32'h300, 5'd9, 1, 1, 0, 5'd0, 0, 5'd0);
        edge_update();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_instr($urandom, 5'($urandom_range(31)), 1, 0, 1, 5'd9, 1, 5'd9);
            hold_i = 1;
            #1;
            checks++;
            if (load_use_stall_o !== 1'b0) begin
                failures++; $display("FAIL hold_stall cyc=%0d got=%b exp=0", i, load_use_stall_o);
            end
            edge_update();
            checks++;
            if (pc_ex_o !== 32'h300 || valid_ex_o !== 1'b1 || mem_re_ex_o !== 1'b1 || rd_addr_ex_o !== 5'd9) begin
                failures++; $display("FAIL hold_frozen cyc=%0d pc=%h valid=%b mem_re=%b exp 300/1/1", i, pc_ex_o, valid_ex_o, mem_re_ex_o);
            end
        end
        @(negedge clk);
        hold_i = 0;
        drive_instr(32'h400, 5'd3, 1, 0, 0, 5'd9, 0, 5'd9);
        edge_update();
        checks++;
        if (pc_ex_o !== 32'h400 || valid_ex_o !== 1'b1 || rd_addr_ex_o !== 5'd3) begin
            failures++; $display("FAIL hold_release pc=%h valid=%b rd=%0d exp 400/1/3", pc_ex_o, valid_ex_o, rd_addr_ex_o);
        end
    endtask

    task automatic test_random();
        bit exp_stall;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            rand_id();
            valid_id_i    = ($urandom_range(3) != 0);
            rs1_addr_id_i = 5'($urandom_range(3));
            rs2_addr_id_i = 5'($urandom_range(3));
            rd_addr_id_i  = 5'($urandom_range(3));
            flush_i       = ($urandom_range(7) == 0);
            hold_i        = ($urandom_range(7) == 0);
            exp_stall = model_stall();
            #1;
            checks++;
            if (load_use_stall_o !== exp_stall) begin
                failures++; $display("FAIL rand_stall n=%0d got=%b exp=%b", n, load_use_stall_o, exp_stall);
            end
            edge_update();
            checks++;
            if ({valid_ex_o, rd_we_ex_o, mem_re_ex_o, mem_we_ex_o} !== {m_valid, m_rd_we, m_mem_re, m_mem_we}) begin
                failures++;
                $display("FAIL rand_ctrl n=%0d got=%b%b%b%b exp=%b%b%b%b", n, valid_ex_o, rd_we_ex_o, mem_re_ex_o,
                         mem_we_ex_o, m_valid, m_rd_we, m_mem_re, m_mem_we);
            end
            checks++;
            if (bubble_cnt_o !== CNT_W'(m_cnt)) begin
                failures++; $display("FAIL rand_cnt n=%0d got=%0d exp=%0d", n, bubble_cnt_o, m_cnt);
            end
            if (m_data_ok) begin
                checks++;
                if ({pc_ex_o, rs1_data_ex_o, rs2_data_ex_o, imm_ex_o, alu_op_ex_o, rd_addr_ex_o} !==
                    {m_pc, m_rs1, m_rs2, m_imm, m_alu, m_rd}) begin
                    failures++; $display("FAIL rand_data n=%0d pc=%h exp=%h rd=%0d exp=%0d", n, pc_ex_o, m_pc, rd_addr_ex_o, m_rd);
                end
            end
        end
        @(negedge clk);
        flush_i = 0; hold_i = 0;
    endtask

    task automatic do_load_use_pair(input logic [31:0] pc);
        @(negedge clk);
        drive_instr(pc, 5'd5, 1, 1, 0, 5'd0, 0, 5'd0);
        edge_update();
        @(negedge clk);
        drive_instr(pc + 32'd4, 5'd6, 1, 0, 0, 5'd0, 1, 5'd5);
        edge_update();
        edge_update();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < CNT_MAX + 2; i++) begin
            do_load_use_pair(32'h1000 + 32'(i * 8));
            checks++;
            if (bubble_cnt_o !== CNT_W'(m_cnt)) begin
                failures++; $display("FAIL sat_step i=%0d got=%0d exp=%0d", i, bubble_cnt_o, m_cnt);
            end
        end
        checks++;
        if (bubble_cnt_o !== CNT_W'(CNT_MAX)) begin
            failures++; $display("FAIL sat_final got=%0d exp=%0d", bubble_cnt_o, CNT_MAX);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        rst = 1;
        model_reset();
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 7; i++) do_load_use_pair(32'h2000 + 32'(i * 8));
        checks++;
        if (bubble_cnt_o !== CNT_W'(7) || valid_ex_o !== 1'b1) begin
            failures++; $display("FAIL async_pre cnt=%0d valid=%b exp 7/1", bubble_cnt_o, valid_ex_o);
        end
        #2;
        rst = 1;
        model_reset();
        #1;
        checks++;
        if ({valid_ex_o, pc_ex_o, rs1_data_ex_o, rs2_data_ex_o, imm_ex_o, alu_op_ex_o, rd_we_ex_o,
             rd_addr_ex_o, mem_re_ex_o, mem_we_ex_o, bubble_cnt_o, load_use_stall_o} !== '0) begin
            failures++; $display("FAIL async_clear valid=%b pc=%h cnt=%0d stall=%b", valid_ex_o, pc_ex_o, bubble_cnt_o, load_use_stall_o);
        end
        @(negedge clk);
        rst = 0;
        drive_instr(32'h700, 5'd4, 1, 0, 0, 5'd0, 0, 5'd0);
        edge_update();
        checks++;
        if (valid_ex_o !== 1'b1 || pc_ex_o !== 32'h700 || bubble_cnt_o !== '0) begin
            failures++; $display("FAIL async_resume valid=%b pc=%h cnt=%0d exp 1/700/0", valid_ex_o, pc_ex_o, bubble_cnt_o);
        end
    endtask

    initial begin
        test_reset();
        test_plain_flow();
        test_load_use();
        test_no_false_stall();
        test_flush_vs_hazard();
        test_hold();
        test_random();
        test_saturation();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
